dma_periph_req: RTL

DMA_PERIPH_REQ -- requirements
Module: dma_periph_req

---
 rtl/dma_periph_req.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dma_periph_req.sv
// Peripheral-side DMA request block: a small first-word-fall-through FIFO that the
// device fills. It raises DREQ to an 8237-style controller and drains on IOR_N rising edges under DACK.
module dma_periph_req #(
    parameter int DEPTH           = 8,
    parameter int THRESHOLD       = 1,
    parameter int DEMAND          = 0,
    parameter int DREQ_ACTIVE_LOW = 0,
    parameter int DACK_ACTIVE_LOW = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       WR_EN,
    input  logic [7:0] WR_DATA,
    output logic       FULL,
    output logic [4:0] LEVEL,
    output logic       DREQ,
    input  logic       DACK,
    input  logic       IOR_N,
    input  logic       EOP_N,
    output logic [7:0] DB_OUT,
    output logic       DB_OE,
    output logic       TC_SEEN,
    input  logic       CLR_TC,
    output logic       OVF,
    output logic       UDF
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_L  = 5'(DEPTH);
    localparam logic [4:0] THR_L    = 5'(THRESHOLD);
    localparam logic       DREQ_POL = (DREQ_ACTIVE_LOW != 0);
    localparam logic       DACK_POL = (DACK_ACTIVE_LOW != 0);
    localparam logic       DEMAND_L = (DEMAND != 0);

    typedef enum logic [1:0] {IDLE, REQ, XFER, RECOVER} stateT;

    stateT          state, stateNxt;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wrPtr, rdPtr;
    logic [4:0]     count;
    logic           live;
    logic           iorPrev, dackPrev;
    logic           tcSeen, ovf, udf, xferDone;
    logic           dackAct, iorRise, pop, push, full, eopHit, reqInt;

    assign dackAct = DACK ^ DACK_POL;
    assign full    = (count == DEPTH_L);
    // live gates the first edge after reset release so no push/pop can slip through
    assign iorRise = live & IOR_N & ~iorPrev & dackAct & dackPrev;
    assign pop     = iorRise & (count != 5'd0);
    // a pop in the same cycle frees a slot, so a push while full still lands
    assign push    = live & WR_EN & (~full | pop);
    assign eopHit  = ~EOP_N & ((state == REQ) | (state == XFER));

    always_ff @(posedge CLK) begin
        if (push) mem[wrPtr] <= WR_DATA;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= 5'd0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            live     <= 1'b0;
            iorPrev  <= 1'b1;
            dackPrev <= 1'b0;
            tcSeen   <= 1'b0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
            xferDone <= 1'b0;
            state    <= IDLE;
        end else begin
            live     <= 1'b1;
            iorPrev  <= IOR_N;
            dackPrev <= dackAct;
            ovf      <= live & WR_EN & full & ~pop;
            udf      <= iorRise & (count == 5'd0);
            if (eopHit)      tcSeen <= 1'b1;
            else if (CLR_TC) tcSeen <= 1'b0;
            if (state != XFER) xferDone <= 1'b0;
            else if (pop)      xferDone <= 1'b1;
            state    <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        reqInt   = 1'b0;
        case (state)
            IDLE: begin
                if ((count >= THR_L) && !tcSeen) stateNxt = REQ;
            end
            REQ: begin
                reqInt = ~tcSeen;
                // an EOP with no ack pending would otherwise strand us in REQ
                if (dackAct)     stateNxt = XFER;
                else if (eopHit) stateNxt = RECOVER;
            end
            XFER: begin
                reqInt = ~tcSeen & (DEMAND_L ? (count != 5'd0) : ~xferDone);
                if (!dackAct) stateNxt = RECOVER;
            end
            default: stateNxt = IDLE;
        endcase
    end

    assign FULL    = full;
    assign LEVEL   = count;
    assign DREQ    = reqInt ^ DREQ_POL;
    assign DB_OUT  = (count != 5'd0) ? mem[rdPtr] : 8'h00;
    assign DB_OE   = RESET & dackAct & ~IOR_N;
    assign TC_SEEN = tcSeen;
    assign OVF     = ovf;
    assign UDF     = udf;

endmodule
